audio_sample_conditioner: RTL and testbench

Downstream of the XADC sampling stage. Turns the free-running 16-bit auxiliary-channel reading (top 12 bits valid) into a fixed-rate, signed, optionally DC-blocked audio sample stream with a valid/ready handshake. It decimates by boxcar-averaging 2^OSR_LOG2 sub-samples and feeds the looper's record path.

---
 rtl/audio_sample_conditioner_if.sv | 10 +
 rtl/audio_sample_conditioner.sv | 105 ++++++++++
 tb/tb_audio_sample_conditioner.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/audio_sample_conditioner_if.sv
// Sample-stream handshake between audio_sample_conditioner and its consumer.
// master drives m_data/m_valid, slave answers with m_ready.
interface audio_sample_conditioner_if;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/audio_sample_conditioner.sv
// Decimates the XADC aux reading into a signed 16-bit audio stream (boxcar of 2^OSR_LOG2 sub-samples).
// Optional first-order DC blocker enabled by defining AUDIO_DCBLOCK_EN.
module audio_sample_conditioner #(
    parameter int unsigned SUB_DIV  = 520,
    parameter int unsigned OSR_LOG2 = 2,
    parameter int unsigned DC_SHIFT = 10
) (
    input  logic                               CLK100MHZ,
    input  logic                               rst,
    input  logic [15:0]                        aux_data,
    audio_sample_conditioner_if.master         m,
    output logic                               overrun
);

    localparam int unsigned TICK_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
    localparam int unsigned ACC_W  = 12 + OSR_LOG2;

    localparam logic [0:0] ST_ACC    = 1'b0;
    localparam logic [0:0] ST_FILTER = 1'b1;

    logic [TICK_W-1:0]   tick_cnt;
    logic                tick;
    logic [OSR_LOG2-1:0] sub_cnt;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    sum;
    logic [ACC_W-1:0]    hold;
    logic [0:0]          state;
    logic [11:0]         avg;
    logic [15:0]         x;
    logic [15:0]         y;

    assign tick = (tick_cnt == TICK_W'(SUB_DIV - 1));
    assign sum  = acc + ACC_W'(aux_data[15:4]);

    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            tick_cnt <= '0;
            sub_cnt  <= '0;
            acc      <= '0;
            hold     <= '0;
            state    <= ST_ACC;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (state == ST_FILTER)
                state <= ST_ACC;
            if (tick) begin
                sub_cnt <= sub_cnt + 1'b1;
                if (sub_cnt == '1) begin
                    hold  <= sum;
                    acc   <= '0;
                    state <= ST_FILTER;
                end else begin
                    acc <= sum;
                end
            end
        end
    end

    // Offset-binary to two's complement: subtracting 2048 from a 12-bit value flips its MSB.
    assign avg = hold[ACC_W-1:OSR_LOG2];
    assign x   = {~avg[11], avg[10:0], 4'b0000};

`ifdef AUDIO_DCBLOCK_EN
    localparam int unsigned DC_W = 16 + DC_SHIFT;

    logic signed [DC_W-1:0] dc_acc;
    logic signed [15:0]     est;
    logic signed [16:0]     diff;

    assign est  = dc_acc[DC_W-1:DC_SHIFT];
    assign diff = $signed({x[15], x}) - $signed({est[15], est});

    always_comb begin
        y = diff[15:0];
        if (diff[16] != diff[15])
            y = diff[16] ? 16'h8000 : 16'h7FFF;
    end

    always_ff @(posedge CLK100MHZ) begin
        if (rst)
            dc_acc <= '0;
        else if (state == ST_FILTER)
            dc_acc <= dc_acc + {{(DC_W-17){diff[16]}}, diff};
    end
`else
    assign y = x;
`endif

    // A load on the same edge as an acceptance keeps m_valid high and is not an overrun.
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            m.m_data  <= '0;
            m.m_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (state == ST_FILTER) begin
            m.m_data  <= y;
            m.m_valid <= 1'b1;
            if (m.m_valid && !m.m_ready)
                overrun <= 1'b1;
        end else if (m.m_valid && m.m_ready) begin
            m.m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_audio_sample_conditioner.sv
// Bench for audio_sample_conditioner (default build): table vectors, timing/handshake sequences,
// and randomized input checked every cycle against a cycle-count based reference model.
module tb_audio_sample_conditioner;

    localparam int unsigned SUB_DIV  = 520;
    localparam int unsigned OSR_LOG2 = 2;
    localparam int unsigned DC_SHIFT = 10;
    localparam int unsigned PERIOD   = SUB_DIV << OSR_LOG2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] aux_data = '0;
    logic        m_ready = 1'b1;
    logic        overrun;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    audio_sample_conditioner_if bus ();
    assign bus.m_ready = m_ready;

    audio_sample_conditioner #(
        .SUB_DIV  (SUB_DIV),
        .OSR_LOG2 (OSR_LOG2),
        .DC_SHIFT (DC_SHIFT)
    ) dut (
        .CLK100MHZ (clk),
        .rst       (rst),
        .aux_data  (aux_data),
        .m         (bus),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: n counts edges since reset release; every SUB_DIV-th edge captures a
    // sub-sample, every 2^OSR_LOG2 captures yield a sample that appears one edge later.
    int          n;
    int          win_sum;
    int          win_cnt;
    bit          pend;
    logic [15:0] pend_y;
    bit          exp_valid;
    logic [15:0] exp_data;
    bit          exp_ovr;
    longint      dc;

    function automatic logic [15:0] convert(input int average);
        int xv;
        xv = (average - 2048) * 16;
`ifdef AUDIO_DCBLOCK_EN
        begin
            longint est, d;
            est = dc >>> DC_SHIFT;
            d   = longint'(xv) - est;
            dc  = dc + d;
            if (d > 32767) d = 32767;
            if (d < -32768) d = -32768;
            return 16'(d);
        end
`else
        return 16'(xv);
`endif
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                n = 0; win_sum = 0; win_cnt = 0; pend = 0; pend_y = '0;
                exp_valid = 0; exp_data = '0; exp_ovr = 0; dc = 0;
            end else begin
                if (pend) begin
                    if (exp_valid && !m_ready) exp_ovr = 1;
                    exp_data  = pend_y;
                    exp_valid = 1;
                    pend      = 0;
                end else if (exp_valid && m_ready) begin
                    exp_valid = 0;
                end
                n++;
                if (n % SUB_DIV == 0) begin
                    win_sum += int'(aux_data[15:4]);
                    win_cnt++;
                    if (win_cnt == (1 << OSR_LOG2)) begin
                        pend_y  = convert(win_sum / (1 << OSR_LOG2));
                        pend    = 1;
                        win_sum = 0;
                        win_cnt = 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("model_m_valid", 32'(bus.m_valid), 32'(exp_valid));
                check("model_m_data", 32'(bus.m_data), 32'(exp_data));
                check("model_overrun", 32'(overrun), 32'(exp_ovr));
            end
        end
    end

    task automatic wait_valid(input int limit, output int cycles);
        cycles = 0;
        while (!bus.m_valid && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
        if (!bus.m_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_valid: m_valid still 0 after %0d cycles, required within %0d", cycles, limit);
        end
    endtask

    typedef struct {
        logic [15:0] aux;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int c;

        vecs[0] = '{16'hFFF0, 16'h7FF0};
        vecs[1] = '{16'h0000, 16'h8000};
        vecs[2] = '{16'h800F, 16'h0000};
        vecs[3] = '{16'h7FFF, 16'hFFF0};
        vecs[4] = '{16'hABCD, 16'h2BC0};
        vecs[5] = '{16'h0010, 16'h8010};

        // Reset state
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_m_data", 32'(bus.m_data), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        // First-sample latency, pulse width and output period
        aux_data = 16'h800F;
        rst = 1'b0;
        wait_valid(PERIOD + 200, c);
        check("first_valid_edges", 32'(c), 32'(PERIOD + 1));
        check("first_data_midscale", 32'(bus.m_data), 32'h0000);
        @(negedge clk);
        check("pulse_width_1", 32'(bus.m_valid), 32'd0);
        wait_valid(PERIOD + 200, c);
        check("output_period", 32'(c + 1), 32'(PERIOD));

        // Table of constant inputs
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            aux_data = vecs[i].aux;
            wait_valid(PERIOD + 200, c);
            check($sformatf("vec%0d_data", i), 32'(bus.m_data), 32'(vecs[i].exp_data));
        end

        // Alternating sub-samples average to 0x200
        @(negedge clk);
        aux_data = 16'h1000;
        repeat (SUB_DIV) @(negedge clk);
        aux_data = 16'h3000;
        repeat (SUB_DIV) @(negedge clk);
        aux_data = 16'h1000;
        repeat (SUB_DIV) @(negedge clk);
        aux_data = 16'h3000;
        wait_valid(PERIOD + 200, c);
        check("alternating_data", 32'(bus.m_data), 32'hA000);

        // Overrun: consumer stalls across two output periods
        @(negedge clk);
        m_ready  = 1'b0;
        aux_data = 16'h4000;
        wait_valid(PERIOD + 200, c);
        check("stall_first_data", 32'(bus.m_data), 32'hC000);
        check("stall_no_overrun_yet", 32'(overrun), 32'd0);
        aux_data = 16'hFFF0;
        repeat (PERIOD) @(negedge clk);
        check("overrun_set", 32'(overrun), 32'd1);
        check("overrun_valid", 32'(bus.m_valid), 32'd1);
        check("overrun_data", 32'(bus.m_data), 32'h7FF0);
        m_ready = 1'b1;
        @(negedge clk);
        check("accept_drops_valid", 32'(bus.m_valid), 32'd0);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Reset after 3 of 4 ticks discards the partial sum and restarts the tick phase
        aux_data = 16'h0000;
        wait_valid(PERIOD + 200, c);
        repeat (3 * SUB_DIV + 100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_clears_overrun", 32'(overrun), 32'd0);
        aux_data = 16'hFFF0;
        wait_valid(PERIOD + 200, c);
        check("post_rst_latency", 32'(c), 32'(PERIOD + 1));
        check("post_rst_data", 32'(bus.m_data), 32'h7FF0);

        // Randomized input and back-pressure, checked by the model every cycle
        repeat (8 * PERIOD) begin
            @(negedge clk);
            aux_data = 16'($urandom);
            m_ready  = ($urandom_range(0, 3) != 0);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
